// File: rtl/rx_pkg.sv
// rx_pkg: shared FSM encoding and parity helper for the RX frame checker
package rx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  // Expected parity bit from the running XOR of the data bits
  function automatic logic exp_parity(input logic acc, input logic typ);
    return (typ == PAR_ODD) ? ~acc : acc;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority
module sat_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);
  // Count up on inc, hold at all-ones, clear wins over increment
  always_ff @(posedge CLK)
    if (!RST) cnt <= '0;
    else cnt <= clr ? '0 : (inc && cnt != '1) ? cnt + CNT_WIDTH'(1) : cnt;
endmodule

// File: rtl/rx_frame_check.sv
// rx_frame_check: strobe-driven UART frame deserialiser with parity/stop checking
module rx_frame_check
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_STOP = 2,
  parameter int CNT_WIDTH = 8,
  localparam int SW = $clog2(MAX_STOP + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_en,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [SW-1:0]         stop_bits,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);
  localparam int BW = $clog2(DATA_WIDTH);
  state_t state, next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] stop_cnt, stop_q, stop_lim;
  logic par_acc, par_mis, par_en_q, par_typ_q;
  logic fin, stp_fail, act;
  assign act = rx_en && bit_valid;
  assign stop_lim = (stop_bits == '0) ? SW'(1) : (stop_bits > SW'(MAX_STOP)) ? SW'(MAX_STOP) : stop_bits;
  // State register
  always_ff @(posedge CLK)
    if (!RST) state <= IDLE;
    else state <= next;
  // Next state and frame-end detection; only strobed cycles advance the FSM
  always_comb begin
    next = state;
    fin = 1'b0;
    stp_fail = 1'b0;
    if (!rx_en) next = IDLE;
    else if (bit_valid)
      case (state)
        IDLE:    next = sampled_bit ? IDLE : DATA;
        DATA:    next = (bit_cnt == BW'(DATA_WIDTH - 1)) ? (par_en_q ? PARITY : STOP) : DATA;
        PARITY:  next = STOP;
        default: begin
          stp_fail = ~sampled_bit;
          fin = stp_fail || (stop_cnt == stop_q - SW'(1));
          next = fin ? IDLE : STOP;
        end
      endcase
  end
  // Datapath: config latch, shifting, parity tracking and registered frame-end flags
  always_ff @(posedge CLK)
    if (!RST) begin
      p_data <= '0;
      shift_reg <= '0;
      bit_cnt <= '0;
      stop_cnt <= '0;
      stop_q <= SW'(1);
      par_acc <= 1'b0;
      par_mis <= 1'b0;
      par_en_q <= 1'b0;
      par_typ_q <= 1'b0;
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
      busy <= (next != IDLE);
      if (act)
        case (state)
          IDLE: if (!sampled_bit) begin
            bit_cnt <= '0;
            stop_cnt <= '0;
            par_acc <= 1'b0;
            par_mis <= 1'b0;
            par_en_q <= par_en;
            par_typ_q <= par_typ;
            stop_q <= stop_lim;
          end
          DATA: begin
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            par_acc <= par_acc ^ sampled_bit;
            bit_cnt <= bit_cnt + BW'(1);
          end
          PARITY: par_mis <= (sampled_bit != exp_parity(par_acc, par_typ_q));
          default: begin
            stop_cnt <= stop_cnt + SW'(1);
            if (fin) begin
              par_err <= par_mis;
              stp_err <= stp_fail;
              data_valid <= !par_mis && !stp_fail;
              if (!par_mis && !stp_fail) p_data <= shift_reg;
            end
          end
        endcase
    end
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
    .CLK(CLK), .RST(RST), .inc(par_err), .clr(err_clr), .cnt(par_err_cnt)
  );
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
    .CLK(CLK), .RST(RST), .inc(stp_err), .clr(err_clr), .cnt(stp_err_cnt)
  );
endmodule
